// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART state encodings, data width and default baud divisor
package uart_defs;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int DEFAULT_CLK_DIV = 434;

    // Parity over one data byte; odd=1 inverts the even-parity result.
    function automatic logic byte_parity(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter 0..CLK_DIV-1 with clear/enable and bit_end flag
module uart_baud_cnt
    import uart_defs::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clock,
    input  logic sclr,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] count;

    // Free-running bit timer: wraps at the last clock of each bit, held at zero when cleared.
    always_ff @(posedge clock or negedge sclr) begin
        if (!sclr) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= bit_end ? 16'd0 : count + 16'd1;
        end
    end

    assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - 8N1 UART transmitter draining a show-ahead byte FIFO; UART_TX_PARITY_EN adds a parity bit
module uart_tx_fifo_drain
    import uart_defs::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clock,
    input  logic       sclr,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_q,
    output logic       fifo_rdreq,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    uart_state_t state;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic        bit_end;
    logic        last_stop;
    logic        load;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clock   (clock),
        .sclr    (sclr),
        .clear   (load || (state == IDLE)),
        .enable  (state != IDLE),
        .bit_end (bit_end)
    );

    assign last_stop  = (STOP_BITS == 1) || stop_idx;
    assign frame_done = (state == STOP) && bit_end && last_stop;

    // A new byte is taken either from IDLE or straight out of the final stop bit,
    // which gives back-to-back frames with no idle gap.
    assign load = tx_en && !fifo_empty &&
                  ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

    // Reset holds the FSM in IDLE; gating keeps a held reset from popping the FIFO.
    assign fifo_rdreq = load && sclr;

    // Frame sequencer: tx is registered so the line never glitches between bits.
    always_ff @(posedge clock or negedge sclr) begin
        if (!sclr) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            shift      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (load) begin
            shift      <= fifo_q;
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= byte_parity(fifo_q, PARITY_ODD[0]);
`endif
        end else begin
            case (state)
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                            stop_idx <= 1'b0;
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - directed self-checking bench for uart_tx_fifo_drain at CLK_DIV=4
module tb_uart_tx_fifo_drain;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clock = 1'b0;
    logic sclr  = 1'b0;
    logic tx_en = 1'b0;

    always #5 clock = ~clock;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];
    int         wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    logic       empty_a, empty_b;
    logic [7:0] q_a, q_b;
    logic       rdreq_a, tx_a, busy_a, done_a;
    logic       rdreq_b, tx_b, busy_b, done_b;

    int   checks = 0;
    int   errors = 0;
    logic last_par = 1'b0;

    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);
    assign q_a     = mem_a[rd_a[4:0]];
    assign q_b     = mem_b[rd_b[4:0]];

    always @(posedge clock) begin
        if (!sclr) rd_a <= wr_a;
        else if (rdreq_a) rd_a <= rd_a + 1;
    end

    always @(posedge clock) begin
        if (!sclr) rd_b <= wr_b;
        else if (rdreq_b) rd_b <= rd_b + 1;
    end

    uart_tx_fifo_drain #(.CLK_DIV(DIV), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clock(clock), .sclr(sclr), .tx_en(tx_en), .fifo_empty(empty_a), .fifo_q(q_a),
        .fifo_rdreq(rdreq_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    uart_tx_fifo_drain #(.CLK_DIV(DIV), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clock(clock), .sclr(sclr), .tx_en(tx_en), .fifo_empty(empty_b), .fifo_q(q_b),
        .fifo_rdreq(rdreq_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    task automatic push_a(input logic [7:0] v);
        mem_a[wr_a[4:0]] = v;
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [7:0] v);
        mem_b[wr_b[4:0]] = v;
        wr_b = wr_b + 1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input logic odd, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR == 1 && idx == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    task automatic check_frame(input int which, input logic [7:0] b, input logic more, input int drop_at);
        int   stops;
        int   fl;
        logic odd;
        logic t, bz, fd, rq;
        stops = (which != 0) ? 2 : 1;
        odd   = (which != 0);
        fl    = (10 + stops - 1 + PAR) * DIV;
        for (int j = 1; j <= fl; j++) begin
            @(negedge clock);
            t  = (which != 0) ? tx_b    : tx_a;
            bz = (which != 0) ? busy_b  : busy_a;
            fd = (which != 0) ? done_b  : done_a;
            rq = (which != 0) ? rdreq_b : rdreq_a;
            checks++;
            if (t !== exp_bit(b, odd, (j-1)/DIV)) begin
                errors++;
                $display("FAIL tx byte %02h cycle %0d: got %b want %b", b, j, t, exp_bit(b, odd, (j-1)/DIV));
            end
            checks++;
            if (bz !== 1'b1) begin
                errors++;
                $display("FAIL busy byte %02h cycle %0d: got %b want 1", b, j, bz);
            end
            checks++;
            if (fd !== (j == fl)) begin
                errors++;
                $display("FAIL frame_done byte %02h cycle %0d: got %b want %b", b, j, fd, (j == fl));
            end
            checks++;
            if (rq !== (more && (j == fl))) begin
                errors++;
                $display("FAIL rdreq byte %02h cycle %0d: got %b want %b", b, j, rq, (more && (j == fl)));
            end
            if (PAR == 1 && (j-1)/DIV == 9) last_par = t;
            if (j == drop_at) tx_en = 1'b0;
        end
    endtask

    task automatic expect_idle_a(input string name, input logic want_rdreq);
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rdreq_a !== want_rdreq) begin
            errors++;
            $display("FAIL %s: got tx=%b busy=%b done=%b rdreq=%b want tx=1 busy=0 done=0 rdreq=%b",
                     name, tx_a, busy_a, done_a, rdreq_a, want_rdreq);
        end
    endtask

    task automatic test_reset;
        tx_en = 1'b1;
        @(negedge clock);
        push_a(8'hC3);
        #1;
        expect_idle_a("reset_a_held", 1'b0);
        checks++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0 || rdreq_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: got tx=%b busy=%b rdreq=%b done=%b want 1 0 0 0", tx_b, busy_b, rdreq_b, done_b);
        end
        repeat (2) @(negedge clock);
        sclr = 1'b1;
        @(negedge clock);
        expect_idle_a("reset_a_release", 1'b0);
    endtask

    task automatic test_single;
        @(negedge clock);
        push_a(8'hA5);
        #1;
        checks++;
        if (rdreq_a !== 1'b1) begin
            errors++;
            $display("FAIL single_rdreq: got %b want 1", rdreq_a);
        end
        check_frame(0, 8'hA5, 1'b0, 0);
        @(negedge clock);
        expect_idle_a("single_after", 1'b0);
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        push_a(8'h00);
        push_a(8'hFF);
        push_a(8'h3C);
        #1;
        checks++;
        if (rdreq_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rdreq: got %b want 1", rdreq_a);
        end
        check_frame(0, 8'h00, 1'b1, 0);
        check_frame(0, 8'hFF, 1'b1, 0);
        check_frame(0, 8'h3C, 1'b0, 0);
        @(negedge clock);
        expect_idle_a("b2b_after", 1'b0);
    endtask

    task automatic test_tx_en_gate;
        @(negedge clock);
        tx_en = 1'b0;
        push_a(8'h5A);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            expect_idle_a("gate_hold", 1'b0);
        end
        tx_en = 1'b1;
        #1;
        checks++;
        if (rdreq_a !== 1'b1) begin
            errors++;
            $display("FAIL gate_release_rdreq: got %b want 1", rdreq_a);
        end
        check_frame(0, 8'h5A, 1'b0, 0);
        @(negedge clock);
        expect_idle_a("gate_after", 1'b0);
    endtask

    task automatic test_tx_en_drop;
        @(negedge clock);
        push_a(8'h11);
        push_a(8'h22);
        #1;
        check_frame(0, 8'h11, 1'b0, 10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            expect_idle_a("drop_hold", 1'b0);
        end
        tx_en = 1'b1;
        #1;
        checks++;
        if (rdreq_a !== 1'b1) begin
            errors++;
            $display("FAIL drop_resume_rdreq: got %b want 1", rdreq_a);
        end
        check_frame(0, 8'h22, 1'b0, 0);
        @(negedge clock);
        expect_idle_a("drop_after", 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clock);
        push_a(8'h55);
        #1;
        repeat (15) @(negedge clock);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before: got %b want 1", busy_a);
        end
        sclr = 1'b0;
        #1;
        expect_idle_a("midreset_async", 1'b0);
        repeat (2) @(negedge clock);
        sclr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            expect_idle_a("midreset_hold", 1'b0);
        end
        push_a(8'h96);
        #1;
        checks++;
        if (rdreq_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_new_rdreq: got %b want 1", rdreq_a);
        end
        check_frame(0, 8'h96, 1'b0, 0);
    endtask

    task automatic test_two_stop;
        @(negedge clock);
        push_b(8'h81);
        #1;
        checks++;
        if (rdreq_b !== 1'b1) begin
            errors++;
            $display("FAIL two_stop_rdreq: got %b want 1", rdreq_b);
        end
        check_frame(1, 8'h81, 1'b0, 0);
        @(negedge clock);
        checks++;
        if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
            errors++;
            $display("FAIL two_stop_after: got busy=%b tx=%b want busy=0 tx=1", busy_b, tx_b);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        @(negedge clock);
        push_a(8'h07);
        #1;
        check_frame(0, 8'h07, 1'b0, 0);
        checks++;
        if (last_par !== 1'b1) begin
            errors++;
            $display("FAIL parity_even_07: got %b want 1", last_par);
        end
        @(negedge clock);
        push_b(8'h03);
        #1;
        check_frame(1, 8'h03, 1'b0, 0);
        checks++;
        if (last_par !== 1'b1) begin
            errors++;
            $display("FAIL parity_odd_03: got %b want 1", last_par);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_tx_en_gate;
        test_tx_en_drop;
        test_reset_mid_frame;
        test_two_stop;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
